wb_arbiter: RTL and testbench

Two-master, one-slave pipelined Wishbone arbiter that shares the system bus between the CPU (master 0) and the USB DMA engine (master 1). It sits in front of the address-decoding interconnect: its slave-side port drives the interconnect's master port. It grants ownership for whole bus cycles (`cyc` tenure) using round-robin priority. It tracks outstanding pipelined strobes so that `ack`/data are always returned to the owner that issued them.

---
 rtl/wb_pkg.sv | 9 +
 rtl/wb_pend_cnt.sv | 29 ++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types and default bus widths.
package wb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    localparam int WB_AW_DEF = 16;
    localparam int WB_DW_DEF = 16;

endpackage

// File: rtl/wb_pend_cnt.sv
// Outstanding-strobe counter: saturating up/down with synchronous clear.
module wb_pend_cnt #(
    parameter int  MAX_PEND = 4,
    localparam int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          full
);

    assign full = (count == CW'(MAX_PEND));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter; grants whole cyc tenures and
// routes acks only to the owner that issued the outstanding strobes.
//
// state    | meaning
// ARB_IDLE | no owner, slave side quiet
// ARB_OWN0 | CPU (master 0) owns the bus
// ARB_OWN1 | USB DMA (master 1) owns the bus
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int AW       = WB_AW_DEF,
    parameter int DW       = WB_DW_DEF,
    parameter int MAX_PEND = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack,
    output logic          m0_stall,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    input  logic          s_stall,
    output logic [1:0]    gnt
);

    localparam int PW = $clog2(MAX_PEND + 1);

    arb_state_t    state;
    logic          last;
    logic [PW-1:0] pend;
    logic          full;
    logic          stb_acc;
    logic          ack_ok;
    logic          rel;

    wb_pend_cnt #(.MAX_PEND(MAX_PEND)) u_pend (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stb_acc),
        .dec   (ack_ok),
        .clr   (rel),
        .count (pend),
        .full  (full)
    );

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_stall = m0_cyc;
        m1_stall = m1_cyc;
        rel      = 1'b0;
        case (state)
            ARB_OWN0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb & ~full;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_i;
                m0_stall = s_stall | full;
                m0_dat_o = s_dat_i;
                rel      = ~m0_cyc;
            end
            ARB_OWN1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb & ~full;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_i;
                m1_stall = s_stall | full;
                m1_dat_o = s_dat_i;
                rel      = ~m1_cyc;
            end
            default: ;
        endcase
        stb_acc = s_stb & ~s_stall;
        // An ack with nothing outstanding (late ack after an abort, or a
        // spurious one) is swallowed; a zero-wait ack of this cycle's strobe is not.
        ack_ok  = s_ack & ((pend != '0) | stb_acc);
        m0_ack  = ack_ok & (state == ARB_OWN0);
        m1_ack  = ack_ok & (state == ARB_OWN1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
            gnt   <= 2'b00;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (m0_cyc && (!m1_cyc || last)) begin
                        state <= ARB_OWN0;
                        gnt   <= 2'b01;
                    end else if (m1_cyc) begin
                        state <= ARB_OWN1;
                        gnt   <= 2'b10;
                    end
                end
                ARB_OWN0: begin
                    if (!m0_cyc) begin
                        last  <= 1'b0;
                        state <= m1_cyc ? ARB_OWN1 : ARB_IDLE;
                        gnt   <= m1_cyc ? 2'b10 : 2'b00;
                    end
                end
                ARB_OWN1: begin
                    if (!m1_cyc) begin
                        last  <= 1'b1;
                        state <= m0_cyc ? ARB_OWN0 : ARB_IDLE;
                        gnt   <= m0_cyc ? 2'b01 : 2'b00;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus scripted corner cases.
module tb_wb_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MAX_PEND = 4;
    localparam int ACK_DLY = 5;

    logic          clk, rst_n;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic          m0_ack, m0_stall, m1_ack, m1_stall;
    logic          s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic [1:0]    gnt;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter #(.AW(AW), .DW(DW), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack(s_ack), .s_stall(s_stall), .gnt(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          stb, we;
        logic [15:0]   adr, dat;
        logic          sstall, sack;
        logic [15:0]   sdat;
        logic          m1cyc;
        logic          x_sstb, x_m0stall, x_m0ack;
        logic [15:0]   x_m0dat;
        logic          x_m1stall;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } sl_t;

    vec_t        vecs [4];
    sl_t         sl_q [$];
    logic [15:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued, exp_pend, n_acked;
        logic done, acc;
        logic [15:0] exp_d;

        vecs[0] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'h0000, 1'b0,
                    1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0,
                    1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b1,
                    1'b0, 1'b0, 1'b0, 16'h1111, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 16'h8001, 16'hA5A5, 1'b0, 1'b1, 16'hC3C3, 1'b0,
                    1'b1, 1'b0, 1'b1, 16'hC3C3, 1'b0};

        rst_n = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat_i = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat_i = '0;
        s_ack = 1'b0; s_stall = 1'b0; s_dat_i = 16'h1234;
        #3;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_scyc", 32'(s_cyc), 32'h0);
        chk("rst_sadr", 32'(s_adr), 32'h0);
        chk("rst_m0stall", 32'(m0_stall), 32'h1);
        chk("rst_m1stall", 32'(m1_stall), 32'h0);
        chk("rst_m0ack", 32'(m0_ack), 32'h0);
        chk("rst_m0dat", 32'(m0_dat_o), 32'h0);
        tick();
        tick();
        m0_cyc = 1'b0; s_dat_i = '0; rst_n = 1'b1;

        // single m0 read
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h2000;
        #2;
        chk("rd_scyc_t", 32'(s_cyc), 32'h0);
        chk("rd_stall_t", 32'(m0_stall), 32'h1);
        tick(); #2;
        chk("rd_gnt", 32'(gnt), 32'h1);
        chk("rd_scyc", 32'(s_cyc), 32'h1);
        chk("rd_sstb", 32'(s_stb), 32'h1);
        chk("rd_sadr", 32'(s_adr), 32'h2000);
        chk("rd_stall", 32'(m0_stall), 32'h0);
        tick();
        m0_stb = 1'b0; s_ack = 1'b1; s_dat_i = 16'hBEEF;
        #2;
        chk("rd_ack", 32'(m0_ack), 32'h1);
        chk("rd_dat", 32'(m0_dat_o), 32'hBEEF);
        chk("rd_m1ack", 32'(m1_ack), 32'h0);
        chk("rd_m1dat", 32'(m1_dat_o), 32'h0);
        tick();
        s_ack = 1'b0; s_dat_i = '0;
        #2;
        chk("rd_pend", 32'(dut.u_pend.count), 32'h0);

        // pass-through vectors while m0 owns
        for (int i = 0; i < 4; i++) begin
            tick();
            m0_stb = vecs[i].stb; m0_we = vecs[i].we; m0_adr = vecs[i].adr;
            m0_dat_i = vecs[i].dat; s_stall = vecs[i].sstall; s_ack = vecs[i].sack;
            s_dat_i = vecs[i].sdat; m1_cyc = vecs[i].m1cyc;
            #2;
            chk($sformatf("vec%0d_sstb", i), 32'(s_stb), 32'(vecs[i].x_sstb));
            chk($sformatf("vec%0d_swe", i), 32'(s_we), 32'(vecs[i].we));
            chk($sformatf("vec%0d_sadr", i), 32'(s_adr), 32'(vecs[i].adr));
            chk($sformatf("vec%0d_sdat", i), 32'(s_dat_o), 32'(vecs[i].dat));
            chk($sformatf("vec%0d_m0stall", i), 32'(m0_stall), 32'(vecs[i].x_m0stall));
            chk($sformatf("vec%0d_m0ack", i), 32'(m0_ack), 32'(vecs[i].x_m0ack));
            chk($sformatf("vec%0d_m0dat", i), 32'(m0_dat_o), 32'(vecs[i].x_m0dat));
            chk($sformatf("vec%0d_m1stall", i), 32'(m1_stall), 32'(vecs[i].x_m1stall));
            chk($sformatf("vec%0d_m1ack", i), 32'(m1_ack), 32'h0);
            chk($sformatf("vec%0d_m1dat", i), 32'(m1_dat_o), 32'h0);
        end
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; s_ack = 1'b0; s_stall = 1'b0; s_dat_i = '0;
        #2;
        chk("rel_scyc", 32'(s_cyc), 32'h0);
        tick(); #2;
        chk("rel_gnt", 32'(gnt), 32'h0);

        // tie after reset, handover, round robin
        tick();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
        m0_cyc = 1'b1; m1_cyc = 1'b1; m0_adr = 16'h0A00; m1_adr = 16'h0B00;
        #2;
        chk("arb_gnt_t", 32'(gnt), 32'h0);
        tick(); #2;
        chk("arb_gnt_m0", 32'(gnt), 32'h1);
        chk("arb_sadr_m0", 32'(s_adr), 32'h0A00);
        chk("arb_m1stall", 32'(m1_stall), 32'h1);
        tick();
        m0_cyc = 1'b0;
        #2;
        chk("hand_scyc", 32'(s_cyc), 32'h0);
        tick(); #2;
        chk("hand_gnt", 32'(gnt), 32'h2);
        chk("hand_scyc1", 32'(s_cyc), 32'h1);
        chk("hand_sadr", 32'(s_adr), 32'h0B00);
        tick();
        m1_cyc = 1'b0;
        tick(); #2;
        chk("arb_idle", 32'(gnt), 32'h0);
        tick();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick(); #2;
        chk("arb_rr", 32'(gnt), 32'h1);
        tick();
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();

        // pipelined burst by m1 against a slow slave
        m1_cyc = 1'b1;
        tick(); #2;
        chk("burst_gnt", 32'(gnt), 32'h2);
        issued = 0; exp_pend = 0; n_acked = 0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            if (sl_q.size() > 0 && sl_q[0].due == c) begin
                s_ack = 1'b1;
                s_dat_i = sl_q[0].data;
                void'(sl_q.pop_front());
            end else begin
                s_ack = 1'b0;
                s_dat_i = '0;
            end
            m1_stb = (issued < 6);
            m1_adr = 16'h4000 + 16'(issued);
            #2;
            chk("burst_stall", 32'(m1_stall), 32'(exp_pend == MAX_PEND));
            chk("burst_sstb", 32'(s_stb), 32'(m1_stb && (exp_pend != MAX_PEND)));
            chk("burst_ack", 32'(m1_ack), 32'(s_ack));
            if (m1_ack) begin
                if (sb_q.size() == 0) begin
                    fail_now("burst_sb_empty");
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("burst_data", 32'(m1_dat_o), 32'(exp_d));
                    n_acked++;
                end
            end
            acc = m1_stb & ~m1_stall;
            if (acc) begin
                sl_q.push_back('{c + ACK_DLY, m1_adr ^ 16'hA5A5});
                sb_q.push_back(m1_adr ^ 16'hA5A5);
                issued++;
            end
            if (acc && !s_ack) exp_pend++;
            else if (!acc && s_ack) exp_pend--;
            if (issued == 6 && sl_q.size() == 0 && sb_q.size() == 0) done = 1'b1;
        end
        chk("burst_done", 32'(done), 32'h1);
        chk("burst_nack", 32'(n_acked), 32'd6);
        tick();
        s_ack = 1'b0; s_dat_i = '0; m1_stb = 1'b0;
        #2;
        chk("burst_pend0", 32'(dut.u_pend.count), 32'h0);
        m1_cyc = 1'b0;
        tick(); #2;
        chk("burst_rel", 32'(gnt), 32'h0);

        // abort with two strobes outstanding
        tick();
        m0_cyc = 1'b1;
        tick();
        m0_stb = 1'b1; m0_adr = 16'h0100;
        #2;
        chk("abt_gnt", 32'(gnt), 32'h1);
        tick();
        m0_adr = 16'h0101;
        #2;
        chk("abt_stall", 32'(m0_stall), 32'h0);
        tick();
        m0_stb = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b1;
        #2;
        chk("abt_pend2", 32'(dut.u_pend.count), 32'h2);
        chk("abt_scyc", 32'(s_cyc), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            s_ack = 1'b1; s_dat_i = 16'hDEAD;
            #2;
            chk("abt_gnt1", 32'(gnt), 32'h2);
            chk("abt_m0ack", 32'(m0_ack), 32'h0);
            chk("abt_m1ack", 32'(m1_ack), 32'h0);
            chk("abt_pend", 32'(dut.u_pend.count), 32'h0);
        end
        tick();
        s_ack = 1'b1; s_dat_i = 16'h7777; m1_stb = 1'b1; m1_adr = 16'h0200;
        #2;
        chk("abt_m1zw_ack", 32'(m1_ack), 32'h1);
        chk("abt_m1zw_dat", 32'(m1_dat_o), 32'h7777);
        tick();
        s_ack = 1'b0; s_dat_i = '0; m1_stb = 1'b0;
        #2;
        chk("abt_pend_end", 32'(dut.u_pend.count), 32'h0);

        // reset in the middle of an m1 burst
        tick();
        m1_stb = 1'b1; m1_adr = 16'h0300;
        tick();
        #2;
        chk("rstm_scyc_pre", 32'(s_cyc), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstm_scyc", 32'(s_cyc), 32'h0);
        chk("rstm_gnt", 32'(gnt), 32'h0);
        chk("rstm_m1stall", 32'(m1_stall), 32'h1);
        chk("rstm_pend", 32'(dut.u_pend.count), 32'h0);
        tick();
        m1_stb = 1'b0; m0_cyc = 1'b1; rst_n = 1'b1;
        tick(); #2;
        chk("rstm_arb", 32'(gnt), 32'h1);
        tick();
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();

        // spurious ack while idle
        tick();
        s_ack = 1'b1; s_dat_i = 16'hFFFF;
        #2;
        chk("sp_gnt", 32'(gnt), 32'h0);
        chk("sp_m0ack", 32'(m0_ack), 32'h0);
        chk("sp_m1ack", 32'(m1_ack), 32'h0);
        chk("sp_m0dat", 32'(m0_dat_o), 32'h0);
        tick();
        s_ack = 1'b0; s_dat_i = '0;
        #2;
        chk("sp_pend", 32'(dut.u_pend.count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
